// File: rtl/lcd_hd44780_responder_pkg.sv
// Shared definitions for the HD44780 panel-side responder.
// Holds the FSM state encoding, init nibble constants and timing defaults.
package lcd_hd44780_responder_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP  = 3'd0,
        ST_INIT2    = 3'd1,
        ST_INIT3    = 3'd2,
        ST_INIT4    = 3'd3,
        ST_READY_HI = 3'd4,
        ST_READY_LO = 3'd5
    } state_t;

    localparam logic [3:0] INIT_NIB_A    = 4'h3;
    localparam logic [3:0] INIT_NIB_LAST = 4'h2;
    localparam logic [7:0] CLEAR_CMD     = 8'h01;

    localparam int DEF_CNT_W       = 20;
    localparam int DEF_T_POWERUP   = 750000;
    localparam int DEF_T_GAP1      = 205000;
    localparam int DEF_T_GAP2      = 5000;
    localparam int DEF_T_GAP3      = 2000;
    localparam int DEF_T_EHIGH_MIN = 12;
    localparam int DEF_T_NIB       = 50;
    localparam int DEF_T_CMD       = 2000;
    localparam int DEF_T_CLEAR     = 82000;

    // Wake-up sequence is 3,3,3 then 2 to switch the panel into 4-bit mode.
    function automatic logic [3:0] init_nibble(input state_t s);
        return (s == ST_INIT4) ? INIT_NIB_LAST : INIT_NIB_A;
    endfunction

endpackage

// File: rtl/lcd_hd44780_responder_e_sampler.sv
// LCD_E edge detector with E-low gap and E-high width counters.
// Captures rs/rw on the rising edge so they stay valid through the fall.
module lcd_hd44780_responder_e_sampler #(
    parameter int CNT_W       = 20,
    parameter int T_EHIGH_MIN = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lcd_e,
    input  logic             lcd_rs,
    input  logic             lcd_rw,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] gap,
    output logic             short_pulse,
    output logic             rs,
    output logic             rw
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] EHIGH_MIN = CNT_W'(T_EHIGH_MIN);

    logic             e_q;
    logic [CNT_W-1:0] hi_cnt;

    assign rise        = lcd_e & ~e_q;
    assign fall        = ~lcd_e & e_q;
    assign short_pulse = fall && (hi_cnt < EHIGH_MIN);

    // hi_cnt ends up equal to the number of cycles lcd_e was sampled high.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q    <= 1'b0;
            gap    <= '0;
            hi_cnt <= '0;
            rs     <= 1'b0;
            rw     <= 1'b0;
        end else begin
            e_q <= lcd_e;
            if (fall)
                gap <= '0;
            else if (gap != CNT_MAX)
                gap <= gap + CNT_W'(1);
            if (rise) begin
                hi_cnt <= CNT_W'(1);
                rs     <= lcd_rs;
                rw     <= lcd_rw;
            end else if (e_q && lcd_e && hi_cnt != CNT_MAX) begin
                hi_cnt <= hi_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Panel-side HD44780 model: checks init sequence and bus timing on the 4-bit bus,
// then reassembles nibble pairs into bytes and models the controller busy window.
module lcd_hd44780_responder
    import lcd_hd44780_responder_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int T_POWERUP   = DEF_T_POWERUP,
    parameter int T_GAP1      = DEF_T_GAP1,
    parameter int T_GAP2      = DEF_T_GAP2,
    parameter int T_GAP3      = DEF_T_GAP3,
    parameter int T_EHIGH_MIN = DEF_T_EHIGH_MIN,
    parameter int T_NIB       = DEF_T_NIB,
    parameter int T_CMD       = DEF_T_CMD,
    parameter int T_CLEAR     = DEF_T_CLEAR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [3:0] sf_d,
    output logic       init_done,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_rs,
    output logic       busy,
    output logic       err_timing,
    output logic       err_seq,
    output logic [2:0] fsm_state
);

    localparam logic [CNT_W-1:0] LEN_CMD   = CNT_W'(T_CMD);
    localparam logic [CNT_W-1:0] LEN_CLEAR = CNT_W'(T_CLEAR);

    logic             rise, fall, short_pulse, rs_cap, rw_cap;
    logic [CNT_W-1:0] gap, min_gap, busy_cnt;
    state_t           state_q, state_d;
    logic             timing_hit, seq_hit, latch_hi, emit_byte, init_accept;
    logic [3:0]       hi_q;
    logic             rs_hi_q;

    lcd_hd44780_responder_e_sampler #(
        .CNT_W      (CNT_W),
        .T_EHIGH_MIN(T_EHIGH_MIN)
    ) u_sampler (
        .clk        (clk),
        .reset      (reset),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .rise       (rise),
        .fall       (fall),
        .gap        (gap),
        .short_pulse(short_pulse),
        .rs         (rs_cap),
        .rw         (rw_cap)
    );

    assign busy      = (busy_cnt != '0);
    assign fsm_state = state_q;

    always_comb begin
        min_gap = '0;
        case (state_q)
            ST_POWERUP:  min_gap = CNT_W'(T_POWERUP);
            ST_INIT2:    min_gap = CNT_W'(T_GAP1);
            ST_INIT3:    min_gap = CNT_W'(T_GAP2);
            ST_INIT4:    min_gap = CNT_W'(T_GAP3);
            ST_READY_LO: min_gap = CNT_W'(T_NIB);
            default:     min_gap = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_POWERUP;
        else       state_q <= state_d;
    end

    // A read pulse is flagged at its rise and then ignored, including its fall.
    always_comb begin
        state_d     = state_q;
        timing_hit  = 1'b0;
        seq_hit     = 1'b0;
        latch_hi    = 1'b0;
        emit_byte   = 1'b0;
        init_accept = 1'b0;
        if (rise) begin
            if (lcd_rw) begin
                seq_hit = 1'b1;
            end else begin
                if (gap < min_gap) timing_hit = 1'b1;
                if (state_q == ST_READY_HI && busy) timing_hit = 1'b1;
            end
        end
        if (fall && !rw_cap) begin
            if (short_pulse) timing_hit = 1'b1;
            case (state_q)
                ST_POWERUP, ST_INIT2, ST_INIT3, ST_INIT4: begin
                    if (sf_d == init_nibble(state_q)) begin
                        case (state_q)
                            ST_POWERUP: state_d = ST_INIT2;
                            ST_INIT2:   state_d = ST_INIT3;
                            ST_INIT3:   state_d = ST_INIT4;
                            default: begin
                                state_d     = ST_READY_HI;
                                init_accept = 1'b1;
                            end
                        endcase
                    end else begin
                        seq_hit = 1'b1;
                    end
                end
                ST_READY_HI: begin
                    latch_hi = 1'b1;
                    state_d  = ST_READY_LO;
                end
                ST_READY_LO: begin
                    emit_byte = 1'b1;
                    if (busy) timing_hit = 1'b1;
                    state_d = ST_READY_HI;
                end
                default: state_d = ST_POWERUP;
            endcase
        end
    end

    // byte_valid is a one-cycle pulse; byte_data/byte_rs hold until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            init_done  <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_rs    <= 1'b0;
            hi_q       <= 4'h0;
            rs_hi_q    <= 1'b0;
            busy_cnt   <= '0;
            err_timing <= 1'b0;
            err_seq    <= 1'b0;
        end else begin
            byte_valid <= emit_byte;
            if (init_accept) init_done  <= 1'b1;
            if (timing_hit)  err_timing <= 1'b1;
            if (seq_hit)     err_seq    <= 1'b1;
            if (latch_hi) begin
                hi_q    <= sf_d;
                rs_hi_q <= rs_cap;
            end
            if (emit_byte) begin
                byte_data <= {hi_q, sf_d};
                byte_rs   <= rs_hi_q;
                busy_cnt  <= ({rs_hi_q, hi_q, sf_d} == {1'b0, CLEAR_CMD}) ? LEN_CLEAR : LEN_CMD;
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - CNT_W'(1);
            end
        end
    end

endmodule
